// File: rtl/gate16_pkg.sv
// Shared definitions for the gate16 arbiter block.
//   OP_*          : two-bit opcodes selecting the bitwise gate operation
//   WIDTH / N_REQ : default operand width and requester count
//   ID_W          : width of the requester id carried with each result
//   slot_state_e  : state of the single result slot (EMPTY / FULL)
package gate16_pkg;

  localparam int WIDTH = 16;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/rr_select.sv
// Round-robin picker, purely combinational.
//   valid_i     : N_REQ request-valid bits
//   last_i      : index of the most recently granted requester
//   grant_o     : one-hot grant (all zeros when no valid bit is set)
//   grant_idx_o : binary index of the granted requester (0 when none)
// The search starts at (last_i + 1) mod N_REQ and wraps once around.
module rr_select
  import gate16_pkg::*;
#(
  parameter int N_REQ_P = N_REQ,
  parameter int ID_W_P  = ID_W
) (
  input  logic [N_REQ_P-1:0] valid_i,
  input  logic [ID_W_P-1:0]  last_i,
  output logic [N_REQ_P-1:0] grant_o,
  output logic [ID_W_P-1:0]  grant_idx_o
);

  logic              found;
  logic [ID_W_P-1:0] idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = '0;
    // k = 1 .. N_REQ_P visits last+1 first and last itself at the very end.
    for (int k = 1; k <= N_REQ_P; k++) begin
      idx = ID_W_P'((int'(last_i) + k) % N_REQ_P);
      if (!found && valid_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/gate16_arbiter.sv
// Arbitrates N_REQ requesters onto one registered bitwise gate unit.
//   clk, reset            : clock, synchronous active-high reset
//   req_valid / req_ready : per-requester handshake, req_ready one-hot or zero
//   req_a, req_b, req_op  : packed per-requester operands and opcodes
//   rsp_valid / rsp_ready : result handshake
//   rsp_data, rsp_id      : registered result and owning requester index
//   dbg_state             : current result-slot state (0 EMPTY, 1 FULL)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Producers hold valid and payload until the transfer; ready may
// change freely; rsp_* is held stable while rsp_valid && !rsp_ready.
module gate16_arbiter
  import gate16_pkg::*;
#(
  parameter int N_REQ = gate16_pkg::N_REQ,
  parameter int WIDTH = gate16_pkg::WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ*2-1:0]     req_op,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   dbg_state
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] a_sel, b_sel, gate_res;
  logic [1:0]       op_sel;

  rr_select #(
    .N_REQ_P (N_REQ),
    .ID_W_P  (ID_W)
  ) u_rr_select (
    .valid_i     (req_valid),
    .last_i      (last_grant_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  // The slot can take a new result if it is empty or is being drained now.
  assign can_accept = (state_q == ST_EMPTY) || rsp_ready;
  // Reset gates the grant so nothing is acknowledged during reset.
  assign req_ready  = (can_accept && !reset) ? grant : '0;
  assign accept     = |req_ready;

  assign a_sel  = req_a[grant_idx*WIDTH +: WIDTH];
  assign b_sel  = req_b[grant_idx*WIDTH +: WIDTH];
  assign op_sel = req_op[grant_idx*2 +: 2];

  always_comb begin
    gate_res = '0;
    case (op_sel)
      OP_AND:  gate_res = a_sel & b_sel;
      OP_OR:   gate_res = a_sel | b_sel;
      OP_XOR:  gate_res = a_sel ^ b_sel;
      OP_NOT:  gate_res = ~a_sel;
      default: gate_res = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      // Drain with no refill empties; drain with refill stays FULL.
      ST_FULL:  if (rsp_ready && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (accept) begin
      data_d       = gate_res;
      id_d         = grant_idx;
      last_grant_d = grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      data_q       <= '0;
      id_q         <= '0;
      last_grant_q <= ID_W'(N_REQ - 1);
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign dbg_state = state_q;

endmodule
